// File: rtl/fdiv_half_precision.sv
// Sequential half-precision (1/5/10) divider: 12-cycle restoring divide on the
// 11-bit significands, then a single normalise/range-check cycle.
module fdiv_half_precision (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       in_Sign_1,
   input  logic [4:0] in_Exponent_1,
   input  logic [9:0] in_Mantissa_1,
   input  logic       in_Sign_2,
   input  logic [4:0] in_Exponent_2,
   input  logic [9:0] in_Mantissa_2,
   output logic       busy,
   output logic       done,
   output logic       out_Sign,
   output logic [4:0] out_Exponent,
   output logic [9:0] out_Mantissa,
   output logic       Exponent_Overflow,
   output logic       Exponent_Underflow,
   output logic       Divide_By_Zero
);

   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_SPECIAL} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] quo_q, quo_d;
   logic [11:0] rem_q, rem_d;
   logic [10:0] dvsr_q, dvsr_d;
   logic [4:0]  e1_q, e1_d, e2_q, e2_d;
   logic        sign_q, sign_d, z1_q, z1_d, z2_q, z2_d;
   logic        busy_q, busy_d, done_q, done_d;
   logic        res_sign_q, res_sign_d;
   logic [4:0]  res_exp_q, res_exp_d;
   logic [9:0]  res_man_q, res_man_d;
   logic        ovf_q, ovf_d, unf_q, unf_d, dbz_q, dbz_d;

   logic [12:0]       trial;
   logic              qbit;
   logic [11:0]       rem_sel;
   logic signed [6:0] exp_raw, exp_fin;
   logic              in_z1, in_z2;

   assign in_z1 = (in_Exponent_1 == 5'd0) && (in_Mantissa_1 == 10'd0);
   assign in_z2 = (in_Exponent_2 == 5'd0) && (in_Mantissa_2 == 10'd0);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      quo_d      = quo_q;
      rem_d      = rem_q;
      dvsr_d     = dvsr_q;
      e1_d       = e1_q;
      e2_d       = e2_q;
      sign_d     = sign_q;
      z1_d       = z1_q;
      z2_d       = z2_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      res_sign_d = res_sign_q;
      res_exp_d  = res_exp_q;
      res_man_d  = res_man_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      dbz_d      = dbz_q;

      // Remainder always stays below the divisor after a trial step, so the
      // 12-bit register never loses its top bit on the shift.
      trial   = {1'b0, rem_q} - {2'b00, dvsr_q};
      qbit    = ~trial[12];
      rem_sel = qbit ? trial[11:0] : rem_q;

      exp_raw = $signed({2'b00, e1_q}) - $signed({2'b00, e2_q}) + 7'sd15;
      exp_fin = quo_q[11] ? exp_raw : exp_raw - 7'sd1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sign_d  = in_Sign_1 ^ in_Sign_2;
               e1_d    = in_Exponent_1;
               e2_d    = in_Exponent_2;
               z1_d    = in_z1;
               z2_d    = in_z2;
               rem_d   = {2'b01, in_Mantissa_1};
               dvsr_d  = {1'b1, in_Mantissa_2};
               quo_d   = 12'd0;
               cnt_d   = 4'd0;
               ovf_d   = 1'b0;
               unf_d   = 1'b0;
               dbz_d   = 1'b0;
               busy_d  = 1'b1;
               state_d = (in_z1 || in_z2) ? S_SPECIAL : S_DIVIDE;
            end
         end
         S_DIVIDE: begin
            quo_d = {quo_q[10:0], qbit};
            rem_d = {rem_sel[10:0], 1'b0};
            if (cnt_q == 4'd11) begin
               cnt_d   = 4'd0;
               state_d = S_NORM;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_NORM: begin
            res_sign_d = sign_q;
            if (exp_fin >= 7'sd31) begin
               ovf_d     = 1'b1;
               res_exp_d = 5'h1f;
               res_man_d = 10'd0;
            end else if (exp_fin <= 7'sd0) begin
               unf_d     = 1'b1;
               res_exp_d = 5'h00;
               res_man_d = 10'd0;
            end else begin
               res_exp_d = exp_fin[4:0];
               res_man_d = quo_q[11] ? quo_q[10:1] : quo_q[9:0];
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         S_SPECIAL: begin
            res_sign_d = sign_q;
            if (z2_q) begin
               dbz_d     = 1'b1;
               res_exp_d = 5'h1f;
               res_man_d = z1_q ? 10'h200 : 10'h000;
            end else begin
               res_exp_d = 5'h00;
               res_man_d = 10'h000;
            end
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         quo_q      <= 12'd0;
         rem_q      <= 12'd0;
         dvsr_q     <= 11'd0;
         e1_q       <= 5'd0;
         e2_q       <= 5'd0;
         sign_q     <= 1'b0;
         z1_q       <= 1'b0;
         z2_q       <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         res_sign_q <= 1'b0;
         res_exp_q  <= 5'd0;
         res_man_q  <= 10'd0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         dbz_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         quo_q      <= quo_d;
         rem_q      <= rem_d;
         dvsr_q     <= dvsr_d;
         e1_q       <= e1_d;
         e2_q       <= e2_d;
         sign_q     <= sign_d;
         z1_q       <= z1_d;
         z2_q       <= z2_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         res_sign_q <= res_sign_d;
         res_exp_q  <= res_exp_d;
         res_man_q  <= res_man_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         dbz_q      <= dbz_d;
      end
   end

   assign busy               = busy_q;
   assign done               = done_q;
   assign out_Sign           = res_sign_q;
   assign out_Exponent       = res_exp_q;
   assign out_Mantissa       = res_man_q;
   assign Exponent_Overflow  = ovf_q;
   assign Exponent_Underflow = unf_q;
   assign Divide_By_Zero     = dbz_q;

endmodule

// File: tb/tb_fdiv_half_precision.sv
// Self-checking bench for fdiv_half_precision: directed vectors, random
// operands against an integer-arithmetic reference, and handshake scenarios.
module tb_fdiv_half_precision;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       s1 = 1'b0, s2 = 1'b0;
   logic [4:0] e1 = '0, e2 = '0;
   logic [9:0] m1 = '0, m2 = '0;
   logic       busy, done, o_s, ovf, unf, dbz;
   logic [4:0] o_e;
   logic [9:0] o_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fdiv_half_precision dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_Sign_1(s1), .in_Exponent_1(e1), .in_Mantissa_1(m1),
      .in_Sign_2(s2), .in_Exponent_2(e2), .in_Mantissa_2(m2),
      .busy(busy), .done(done),
      .out_Sign(o_s), .out_Exponent(o_e), .out_Mantissa(o_m),
      .Exponent_Overflow(ovf), .Exponent_Underflow(unf), .Divide_By_Zero(dbz)
   );

   // Packed result: {sign, exp[4:0], man[9:0], ovf, unf, dbz}
   function automatic logic [18:0] model(input logic a_s, input logic [4:0] a_e, input logic [9:0] a_m,
                                         input logic b_s, input logic [4:0] b_e, input logic [9:0] b_m);
      logic za, zb, sg;
      int   q, ex, man;
      za = (a_e == 0) && (a_m == 0);
      zb = (b_e == 0) && (b_m == 0);
      sg = a_s ^ b_s;
      if (zb) return {sg, 5'h1f, (za ? 10'h200 : 10'h000), 3'b001};
      if (za) return {sg, 5'h00, 10'h000, 3'b000};
      q  = ((1024 + int'(a_m)) * 2048) / (1024 + int'(b_m));
      ex = int'(a_e) - int'(b_e) + 15;
      if (q >= 2048) man = (q >> 1) % 1024;
      else begin
         man = q % 1024;
         ex  = ex - 1;
      end
      if (ex >= 31) return {sg, 5'h1f, 10'h000, 3'b100};
      if (ex <= 0)  return {sg, 5'h00, 10'h000, 3'b010};
      return {sg, 5'(ex), 10'(man), 3'b000};
   endfunction

   function automatic logic [18:0] got();
      return {o_s, o_e, o_m, ovf, unf, dbz};
   endfunction

   function automatic int exp_lat(input logic [4:0] a_e, input logic [9:0] a_m,
                                  input logic [4:0] b_e, input logic [9:0] b_m);
      return ((a_e == 0 && a_m == 0) || (b_e == 0 && b_m == 0)) ? 1 : 13;
   endfunction

   // Called at a negedge; returns at the negedge of the done cycle.
   // lat = number of clock edges after the start edge until done is seen.
   task automatic op(input logic a_s, input logic [4:0] a_e, input logic [9:0] a_m,
                     input logic b_s, input logic [4:0] b_e, input logic [9:0] b_m,
                     output int lat, output logic busy_at_done);
      s1 = a_s; e1 = a_e; m1 = a_m;
      s2 = b_s; e2 = b_e; m2 = b_m;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      s1 = ~a_s; e1 = ~a_e; m1 = ~a_m;
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      busy_at_done = busy;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if ({busy, done, got()} !== 21'd0) begin
         errors++;
         $display("FAIL reset_state got=%h exp=0", {busy, done, got()});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_directed();
      logic [18:0] vec [0:7];
      logic [18:0] ref_r [0:7];
      int lat;
      logic bd;
      vec[0] = {1'b0, 5'b10000, 10'b1000000000}; vec[1] = {1'b0, 5'b01111, 10'b1000000000};
      vec[2] = {1'b0, 5'b01111, 10'b0000000000};
      vec[3] = {1'b1, 5'b10001, 10'b1000000000}; vec[4] = {1'b0, 5'b10000, 10'b0};
      vec[5] = {1'b0, 5'b11110, 10'b0};          vec[6] = {1'b0, 5'b00001, 10'b0};
      vec[7] = {1'b0, 5'b00000, 10'b0};
      // Hand-computed expected results for the listed vector pairs
      ref_r[0] = {1'b0, 5'b10000, 10'b0000000000, 3'b000}; // 3.0/1.5
      ref_r[1] = {1'b0, 5'b01110, 10'b0101010101, 3'b000}; // 1.0/1.5
      ref_r[2] = {1'b1, 5'b10000, 10'b1000000000, 3'b000}; // -6/2
      ref_r[3] = {1'b0, 5'b11111, 10'b0, 3'b001};          // 1/0
      ref_r[4] = {1'b0, 5'b11111, 10'h200, 3'b001};        // 0/0
      ref_r[5] = {1'b0, 5'b00000, 10'b0, 3'b000};          // 0/3
      ref_r[6] = {1'b0, 5'b11111, 10'b0, 3'b100};          // overflow
      ref_r[7] = {1'b0, 5'b00000, 10'b0, 3'b010};          // underflow
      for (int i = 0; i < 8; i++) begin
         logic [15:0] a, b;
         int el;
         case (i)
            0: begin a = vec[0][15:0]; b = vec[1][15:0]; end
            1: begin a = vec[2][15:0]; b = vec[1][15:0]; end
            2: begin a = vec[3][15:0]; b = vec[4][15:0]; end
            3: begin a = vec[2][15:0]; b = vec[7][15:0]; end
            4: begin a = vec[7][15:0]; b = vec[7][15:0]; end
            5: begin a = vec[7][15:0]; b = {1'b0, 5'b10000, 10'b1000000000}; end
            6: begin a = vec[5][15:0]; b = vec[6][15:0]; end
            default: begin a = vec[6][15:0]; b = vec[5][15:0]; end
         endcase
         el = (i >= 3 && i <= 5) ? 1 : 13;
         op(a[15], a[14:10], a[9:0], b[15], b[14:10], b[9:0], lat, bd);
         checks++;
         if (got() !== ref_r[i]) begin
            errors++;
            $display("FAIL directed_%0d result got=%h exp=%h", i, got(), ref_r[i]);
         end
         checks++;
         if (lat != el || bd !== 1'b0) begin
            errors++;
            $display("FAIL directed_%0d timing lat=%0d busy=%b exp lat=%0d busy=0", i, lat, bd, el);
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || got() !== ref_r[i]) begin
            errors++;
            $display("FAIL directed_%0d hold done=%b got=%h exp done=0 %h", i, done, got(), ref_r[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat;
      logic bd;
      for (int i = 0; i < 60; i++) begin
         logic as, bs;
         logic [4:0] ae, be;
         logic [9:0] am, bm;
         logic [18:0] r;
         as = 1'($urandom); bs = 1'($urandom);
         ae = 5'($urandom); be = 5'($urandom);
         am = 10'($urandom); bm = 10'($urandom);
         if ($urandom_range(0, 9) == 0) begin ae = 0; am = 0; end
         if ($urandom_range(0, 9) == 0) begin be = 0; bm = 0; end
         r = model(as, ae, am, bs, be, bm);
         op(as, ae, am, bs, be, bm, lat, bd);
         checks++;
         if (got() !== r || lat != exp_lat(ae, am, be, bm)) begin
            errors++;
            $display("FAIL random_%0d got=%h lat=%0d exp=%h lat=%0d", i, got(), lat, r,
                     exp_lat(ae, am, be, bm));
         end
         if (i % 3 == 0) @(negedge clk);
      end
   endtask

   task automatic test_ignore_start();
      logic [18:0] r;
      int lat;
      r = model(1'b0, 5'b10010, 10'h155, 1'b1, 5'b01101, 10'h2aa);
      s1 = 1'b0; e1 = 5'b10010; m1 = 10'h155;
      s2 = 1'b1; e2 = 5'b01101; m2 = 10'h2aa;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 0;
      while (!done && lat < 40) begin
         if (lat == 5) begin
            s1 = 1'b1; e1 = 5'b00011; m1 = 10'h3ff;
            s2 = 1'b0; e2 = 5'b00000; m2 = 10'h000;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      checks++;
      if (got() !== r || lat != 13) begin
         errors++;
         $display("FAIL ignore_start got=%h lat=%0d exp=%h lat=13", got(), lat, r);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [18:0] r1, r2;
      int lat;
      logic bd;
      r1 = model(1'b0, 5'b10100, 10'h0f0, 1'b0, 5'b10001, 10'h30c);
      r2 = model(1'b1, 5'b01010, 10'h001, 1'b0, 5'b01100, 10'h3fe);
      op(1'b0, 5'b10100, 10'h0f0, 1'b0, 5'b10001, 10'h30c, lat, bd);
      checks++;
      if (got() !== r1 || lat != 13) begin
         errors++;
         $display("FAIL b2b_first got=%h lat=%0d exp=%h lat=13", got(), lat, r1);
      end
      op(1'b1, 5'b01010, 10'h001, 1'b0, 5'b01100, 10'h3fe, lat, bd);
      checks++;
      if (got() !== r2 || lat != 13) begin
         errors++;
         $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=13", got(), lat, r2);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic [18:0] r;
      int lat, seen;
      logic bd;
      s1 = 1'b0; e1 = 5'b10000; m1 = 10'h200;
      s2 = 1'b0; e2 = 5'b01111; m2 = 10'h200;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, got()} !== 21'd0) begin
         errors++;
         $display("FAIL reset_mid_outputs got=%h exp=0", {busy, done, got()});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (16) begin
         @(negedge clk);
         if (done) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done got=%0d pulses exp=0", seen);
      end
      r = model(1'b1, 5'b10011, 10'h07b, 1'b0, 5'b10000, 10'h1c8);
      op(1'b1, 5'b10011, 10'h07b, 1'b0, 5'b10000, 10'h1c8, lat, bd);
      checks++;
      if (got() !== r || lat != 13) begin
         errors++;
         $display("FAIL reset_mid_fresh got=%h lat=%0d exp=%h lat=13", got(), lat, r);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fdiv_half_precision.md
# fdiv_half_precision

Sequential half-precision (1/5/10) floating-point divider: the inverse of the FP multiply path in the same arithmetic library. It accepts two operands split into sign/exponent/mantissa fields and returns the quotient in the same split format. It uses a multi-cycle restoring divider on the 11-bit significands with a start/busy/done handshake, so it sits next to the multiplier in the FP operations block.

## Interface
- No parameters; field widths are fixed at sign 1, exponent 5 (bias 15), mantissa 10.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only in IDLE
- in_Sign_1 / in_Exponent_1 / in_Mantissa_1  in  1/5/10  dividend fields
- in_Sign_2 / in_Exponent_2 / in_Mantissa_2  in  1/5/10  divisor fields
- busy  out  1  operation in progress; start ignored while high
- done  out  1  one-cycle pulse; result outputs valid from this cycle
- out_Sign / out_Exponent / out_Mantissa  out  1/5/10  quotient, registered, held until next done
- Exponent_Overflow  out  1  result exponent ≥ 31; held with result
- Exponent_Underflow  out  1  result exponent ≤ 0; held with result
- Divide_By_Zero  out  1  divisor is zero; held with result

## Operation
- Zero operand: exponent == 0 and mantissa == 0. Otherwise the hidden bit is 1. There is no subnormal, infinity or NaN decoding on inputs.
- Sign: out_Sign = in_Sign_1 XOR in_Sign_2 in all cases.
- States: IDLE, DIVIDE, NORM, SPECIAL.
- IDLE, start=1:
  - Latch the operands. Clear all three flags.
  - If either operand is zero, go to SPECIAL. Otherwise go to DIVIDE with the bit counter at 0.
- SPECIAL (1 cycle) writes the result, pulses done and returns to IDLE:
  - Divisor zero, dividend nonzero: Divide_By_Zero=1, exponent 11111, mantissa 0.
  - Both zero: Divide_By_Zero=1, exponent 11111, mantissa 10'h200 (NaN).
  - Dividend zero, divisor nonzero: exponent 0, mantissa 0.
- DIVIDE (12 cycles): restoring division of {1,m1} by {1,m2}.
  - Produces quotient q[11:0] MSB first, one bit per cycle, with q[11] the 2^0 bit.
  - Partial remainder is 12 bits wide, with a shift-left then trial-subtract each cycle.
  - The counter wraps to NORM after bit 11.
- NORM (1 cycle):
  - E = E1 − E2 + 15, computed as 7-bit signed.
  - If q[11]=1: mantissa = q[10:1], exponent E. Otherwise: mantissa = q[9:0], exponent E−1.
  - Rounding is truncation only.
  - Final exponent ≥ 31: Exponent_Overflow=1, output exponent 11111, mantissa 0.
  - Final exponent ≤ 0: Exponent_Underflow=1, output exponent 0, mantissa 0.
  - Writes the outputs, pulses done and returns to IDLE.

## Timing
- Reset values: busy=0, done=0, all result outputs 0, all flags 0, state IDLE. The counter and quotient registers are also 0.
- Reset asserted mid-operation aborts immediately: no done, outputs return to 0.
- Normal latency: start sampled at edge 0 → DIVIDE on edges 1–12 → NORM at edge 13. done is high for exactly the one cycle following edge 13.
- Special latency: done is high in the cycle following edge 1.
- busy is high from the cycle after start is sampled until the edge that asserts done. It is low during the done cycle.
- A start coincident with the done cycle is accepted, giving back-to-back operation with no idle gap.
- start while busy is ignored. Input fields only need to be stable on the start edge.

## Test plan
- 3.0 / 1.5: (0,10000,1000000000) / (0,01111,1000000000) → (0,10000,0000000000), no flags, done exactly 13 cycles after start, busy low on the done cycle.
- 1.0 / 1.5: (0,01111,0) / (0,01111,1000000000) → (0,01110,0101010101), exercising the q[11]=0 normalize path with truncation.
- −6.0 / 2.0: (1,10001,1000000000) / (0,10000,0) → (1,10000,1000000000).
- Zero divisor and zero operands:
  - 1.0 / 0 → Divide_By_Zero=1, (0,11111,0), done 1 cycle after start.
  - 0 / 0 → (x,11111,10'h200).
  - 0 / 3.0 → (0,00000,0), no flags.
- Range flags:
  - (0,11110,0) / (0,00001,0) → Exponent_Overflow=1, (0,11111,0).
  - (0,00001,0) / (0,11110,0) → Exponent_Underflow=1, (0,00000,0).
- Control sequencing:
  - Pulse start again mid-DIVIDE: ignored, and the first result is unchanged.
  - Start issued on the done cycle: second result arrives 13 cycles later.
  - rst_n low at cycle 6 of DIVIDE: outputs 0 and no done pulse; a fresh start afterwards completes normally.
